// File: rtl/mdio_event_counters_pkg.sv
// Shared MDIO register-map constants and decode types.
// The default addresses and pull-up read value match the c22 register block.
package mdio_event_counters_pkg;

  localparam int          DEFAULT_BASE_ADDR = 16;
  localparam int          DEFAULT_ISR_ADDR  = 26;
  localparam int          DEFAULT_IMR_ADDR  = 27;
  localparam logic [15:0] PULLUP_VALUE      = 16'hffff;

  typedef enum logic [1:0] {
    REG_COUNTER,
    REG_ISR,
    REG_IMR,
    REG_UNKNOWN
  } reg_kind_e;

  function automatic bit addr_in_bank(int a, int base, int n);
    return (a >= base) && (a < base + n);
  endfunction

endpackage

// File: rtl/mdio_sat_counter.sv
// One saturating event counter: registers the strobe, counts it a cycle later,
// and flags the cycle on which the counter MSB rises.
module mdio_sat_counter
  import mdio_event_counters_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             clear_to_event_i,
  output logic [WIDTH-1:0] count_o,
  output logic             msb_rise_o
);

  logic             ev_q;
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (clear_to_event_i) begin
      // Reload with the pending event so a strobe landing on the read is kept.
      count_d    = '0;
      count_d[0] = ev_q;
    end else if (ev_q && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q    <= 1'b0;
      count_q <= '0;
    end else begin
      ev_q    <= event_i;
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign msb_rise_o = ~count_q[WIDTH-1] & count_d[WIDTH-1];

endmodule

// File: rtl/mdio_event_counters.sv
// Bank of saturating event counters with interrupt status/mask registers,
// exposed as Wishbone registers behind the MDIO slave.
module mdio_event_counters
  import mdio_event_counters_pkg::*;
#(
  parameter int CHANNELS       = 5,
  parameter int COUNTER_WIDTH  = 15,
  parameter int BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int ISR_ADDR       = DEFAULT_ISR_ADDR,
  parameter int IMR_ADDR       = DEFAULT_IMR_ADDR,
  parameter bit CLEAR_ON_READ  = 1'b1,
  parameter bit EMULATE_PULLUP = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc,
  input  logic                stb,
  input  logic                we,
  input  logic [4:0]          addr,
  input  logic [15:0]         data_write,
  output logic                ack,
  output logic                err,
  output logic [15:0]         data_read,
  input  logic [CHANNELS-1:0] events,
  output logic                irq
);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $fatal(1, "mdio_event_counters: CHANNELS must be 1..8");
  end
  if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 16) begin : g_bad_width
    $fatal(1, "mdio_event_counters: COUNTER_WIDTH must be 1..16");
  end
  if (BASE_ADDR < 0 || BASE_ADDR + CHANNELS - 1 > 31) begin : g_bad_base
    $fatal(1, "mdio_event_counters: counter bank outside 0..31");
  end
  if (addr_in_bank(ISR_ADDR, BASE_ADDR, CHANNELS) || addr_in_bank(IMR_ADDR, BASE_ADDR, CHANNELS)
      || ISR_ADDR == IMR_ADDR) begin : g_bad_map
    $fatal(1, "mdio_event_counters: ISR/IMR address overlaps");
  end

  logic                     req;
  reg_kind_e                kind;
  logic [CHANNELS-1:0]      cnt_sel;
  logic [COUNTER_WIDTH-1:0] count [CHANNELS];
  logic [CHANNELS-1:0]      msb_rise;
  logic [15:0]              cnt_rd;
  logic                     isr_clr;
  logic                     unused_wdata;

  logic                ack_q, ack_d, err_q, err_d, irq_q;
  logic [15:0]         rdata_q, rdata_d;
  logic [CHANNELS-1:0] isr_q, isr_d, imr_q, imr_d;

  assign req          = cyc & stb;
  assign unused_wdata = ^data_write;

  always_comb begin
    cnt_sel = '0;
    cnt_rd  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_sel[i] = (addr == 5'(BASE_ADDR + int'(i)));
      if (cnt_sel[i]) cnt_rd[COUNTER_WIDTH-1:0] = count[i];
    end
    if (|cnt_sel)                   kind = REG_COUNTER;
    else if (addr == 5'(ISR_ADDR))  kind = REG_ISR;
    else if (addr == 5'(IMR_ADDR))  kind = REG_IMR;
    else                            kind = REG_UNKNOWN;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mdio_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
      .clk              (clk),
      .rst              (rst),
      .event_i          (events[g]),
      .load_i           (req & we & cnt_sel[g]),
      .load_value_i     (data_write[COUNTER_WIDTH-1:0]),
      .clear_to_event_i (CLEAR_ON_READ & req & ~we & cnt_sel[g]),
      .count_o          (count[g]),
      .msb_rise_o       (msb_rise[g])
    );
  end

  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    isr_clr = 1'b0;
    imr_d   = imr_q;
    if (req) begin
      unique case (kind)
        REG_COUNTER: begin
          ack_d   = 1'b1;
          rdata_d = cnt_rd;
        end
        REG_ISR: begin
          ack_d                   = 1'b1;
          rdata_d                 = '0;
          rdata_d[CHANNELS-1:0]   = isr_q;
          isr_clr                 = ~we;
        end
        REG_IMR: begin
          ack_d                   = 1'b1;
          rdata_d                 = '0;
          rdata_d[CHANNELS-1:0]   = imr_q;
          if (we) imr_d = data_write[CHANNELS-1:0];
        end
        default: begin
          if (EMULATE_PULLUP) begin
            ack_d   = 1'b1;
            rdata_d = PULLUP_VALUE;
          end else begin
            err_d   = 1'b1;
          end
        end
      endcase
    end
    // A new MSB rise on the read cycle survives the clear.
    isr_d = (isr_clr ? '0 : isr_q) | msb_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      isr_q   <= '0;
      imr_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      irq_q   <= |(isr_q & imr_q);
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign data_read = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mdio_event_counters.sv
// Bench for two configurations of the event counter block sharing one bus:
// dut0 defaults, dut1 width 4 / non-destructive reads / pull-up emulation.
module tb_mdio_event_counters;

  localparam int NCH = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cyc, stb, we;
  logic [4:0]     addr;
  logic [15:0]    wdata;
  logic [NCH-1:0] events;
  logic           ack0, err0, irq0, ack1, err1, irq1;
  logic [15:0]    rd0, rd1;

  int checks = 0;
  int errors = 0;

  mdio_event_counters #(.CHANNELS(NCH), .COUNTER_WIDTH(15), .CLEAR_ON_READ(1'b1),
                        .EMULATE_PULLUP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
    .data_write(wdata), .ack(ack0), .err(err0), .data_read(rd0),
    .events(events), .irq(irq0));

  mdio_event_counters #(.CHANNELS(NCH), .COUNTER_WIDTH(4), .CLEAR_ON_READ(1'b0),
                        .EMULATE_PULLUP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
    .data_write(wdata), .ack(ack1), .err(err1), .data_read(rd1),
    .events(events), .irq(irq1));

  always #5 clk = ~clk;

  // Reference model: integer counters, clamped at 2**W-1.
  int  m_w[2], m_cor[2], m_ep[2];
  int  m_cnt[2][NCH];
  bit  m_ev[2][NCH];
  int  m_isr[2], m_imr[2], m_data[2];
  bit  m_irq[2], m_ack[2], m_err[2], m_rd[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[d][c] = 0;
        m_ev[d][c]  = 1'b0;
      end
      m_isr[d] = 0; m_imr[d] = 0; m_data[d] = 0;
      m_irq[d] = 0; m_ack[d] = 0; m_err[d] = 0; m_rd[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int maxv = (1 << m_w[d]) - 1;
      int half = 1 << (m_w[d] - 1);
      bit rq   = cyc && stb;
      int a    = int'(addr);
      int ch   = a - 16;
      bit hit  = rq && (a >= 16) && (a < 16 + NCH);
      int rise = 0;
      int nc;
      m_ack[d] = 0; m_err[d] = 0; m_rd[d] = rq && !we;
      if (rq) begin
        if (hit)              begin m_ack[d] = 1; m_data[d] = m_cnt[d][ch]; end
        else if (a == 26)     begin m_ack[d] = 1; m_data[d] = m_isr[d]; end
        else if (a == 27)     begin m_ack[d] = 1; m_data[d] = m_imr[d]; end
        else if (m_ep[d] != 0) begin m_ack[d] = 1; m_data[d] = 16'hffff; end
        else                  m_err[d] = 1;
      end
      m_irq[d] = (m_isr[d] & m_imr[d]) != 0;
      for (int c = 0; c < NCH; c++) begin
        if (hit && c == ch && we)                     nc = int'(wdata) & maxv;
        else if (hit && c == ch && m_cor[d] != 0)     nc = int'(m_ev[d][c]);
        else if (m_ev[d][c])                          nc = (m_cnt[d][c] + 1 > maxv) ? maxv : m_cnt[d][c] + 1;
        else                                          nc = m_cnt[d][c];
        if (m_cnt[d][c] < half && nc >= half) rise |= (1 << c);
        m_cnt[d][c] = nc;
        m_ev[d][c]  = events[c];
      end
      m_isr[d] = ((rq && !we && a == 26) ? 0 : m_isr[d]) | rise;
      if (rq && we && a == 27) m_imr[d] = int'(wdata) & ((1 << NCH) - 1);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_model(input int d, input logic a, input logic e, input logic [15:0] r, input logic q);
    chk($sformatf("dut%0d ack", d), 32'(a), 32'(m_ack[d]));
    chk($sformatf("dut%0d err", d), 32'(e), 32'(m_err[d]));
    chk($sformatf("dut%0d irq", d), 32'(q), 32'(m_irq[d]));
    if (m_ack[d] && m_rd[d]) chk($sformatf("dut%0d data", d), 32'(r), 32'(m_data[d]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cmp_model(0, ack0, err0, rd0, irq0);
    cmp_model(1, ack1, err1, rd1, irq1);
  endtask

  task automatic drive(input bit c, input bit w, input logic [4:0] a, input logic [15:0] wd,
                       input logic [NCH-1:0] ev);
    cyc = c; stb = c; we = w; addr = a; wdata = wd; events = ev;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] ev);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 5'd0, 16'h0, ev);
      cycle();
    end
  endtask

  typedef struct {
    bit          c, w;
    logic [4:0]  a;
    logic [15:0] wd;
    logic [4:0]  ev;
    bit          ack, err;
    logic [15:0] d;
    bit          irq;
  } vec_t;

  function automatic vec_t mkv(bit c, bit w, logic [4:0] a, logic [15:0] wd, logic [4:0] ev,
                               bit ack, bit err, logic [15:0] d, bit irq);
    vec_t v;
    v.c = c; v.w = w; v.a = a; v.wd = wd; v.ev = ev;
    v.ack = ack; v.err = err; v.d = d; v.irq = irq;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    m_w[0] = 15; m_cor[0] = 1; m_ep[0] = 0;
    m_w[1] = 4;  m_cor[1] = 0; m_ep[1] = 1;
    model_reset();

    // dut0 expectations, one row per clock: response to that row's request
    tbl[0]  = mkv(1, 0, 5'd16, 16'h0,    5'h00, 1, 0, 16'h0000, 0);
    tbl[1]  = mkv(1, 0, 5'd26, 16'h0,    5'h00, 1, 0, 16'h0000, 0);
    tbl[2]  = mkv(1, 0, 5'd27, 16'h0,    5'h00, 1, 0, 16'h0000, 0);
    for (int i = 3; i <= 7; i++) tbl[i] = mkv(0, 0, 5'd0, 16'h0, 5'h04, 0, 0, 16'h0, 0);
    tbl[8]  = mkv(0, 0, 5'd0,  16'h0,    5'h00, 0, 0, 16'h0000, 0);
    tbl[9]  = mkv(0, 0, 5'd0,  16'h0,    5'h00, 0, 0, 16'h0000, 0);
    tbl[10] = mkv(1, 0, 5'd18, 16'h0,    5'h00, 1, 0, 16'h0005, 0);
    tbl[11] = mkv(1, 0, 5'd18, 16'h0,    5'h00, 1, 0, 16'h0000, 0);
    tbl[12] = mkv(1, 1, 5'd27, 16'h0001, 5'h00, 1, 0, 16'h0000, 0);
    tbl[13] = mkv(1, 1, 5'd16, 16'h3fff, 5'h00, 1, 0, 16'h0000, 0);
    tbl[14] = mkv(0, 0, 5'd0,  16'h0,    5'h01, 0, 0, 16'h0000, 0);
    tbl[15] = mkv(0, 0, 5'd0,  16'h0,    5'h00, 0, 0, 16'h0000, 0);
    tbl[16] = mkv(0, 0, 5'd0,  16'h0,    5'h00, 0, 0, 16'h0000, 1);
    tbl[17] = mkv(1, 0, 5'd26, 16'h0,    5'h00, 1, 0, 16'h0001, 1);
    tbl[18] = mkv(0, 0, 5'd0,  16'h0,    5'h00, 0, 0, 16'h0000, 0);
    tbl[19] = mkv(1, 0, 5'd16, 16'h0,    5'h00, 1, 0, 16'h4000, 0);
    tbl[20] = mkv(0, 0, 5'd0,  16'h0,    5'h02, 0, 0, 16'h0000, 0);
    tbl[21] = mkv(1, 0, 5'd17, 16'h0,    5'h00, 1, 0, 16'h0000, 0);
    tbl[22] = mkv(1, 0, 5'd17, 16'h0,    5'h00, 1, 0, 16'h0001, 0);
    tbl[23] = mkv(1, 0, 5'd31, 16'h0,    5'h00, 0, 1, 16'h0000, 0);
    tbl[24] = mkv(1, 1, 5'd31, 16'h1234, 5'h00, 0, 1, 16'h0000, 0);
    tbl[25] = mkv(1, 1, 5'd26, 16'hffff, 5'h00, 1, 0, 16'h0000, 0);
    tbl[26] = mkv(1, 0, 5'd26, 16'h0,    5'h00, 1, 0, 16'h0000, 0);
    tbl[27] = mkv(1, 0, 5'd27, 16'h0,    5'h00, 1, 0, 16'h0001, 0);

    drive(0, 0, 5'd0, 16'h0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ack0", 32'(ack0), 0);  chk("reset err0", 32'(err0), 0);
    chk("reset rd0", 32'(rd0), 0);    chk("reset irq0", 32'(irq0), 0);
    chk("reset ack1", 32'(ack1), 0);  chk("reset rd1", 32'(rd1), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].ev);
      cycle();
      chk($sformatf("vec%0d ack", i), 32'(ack0), 32'(tbl[i].ack));
      chk($sformatf("vec%0d err", i), 32'(err0), 32'(tbl[i].err));
      chk($sformatf("vec%0d irq", i), 32'(irq0), 32'(tbl[i].irq));
      if (tbl[i].ack && !tbl[i].w) chk($sformatf("vec%0d data", i), 32'(rd0), 32'(tbl[i].d));
    end

    // Saturation: 0xe plus ten events
    drive(1, 1, 5'd16, 16'h000e, '0); cycle();
    idle(10, 5'h01);
    idle(2, 5'h00);
    drive(1, 0, 5'd16, 16'h0, '0); cycle();
    chk("sat rd0", 32'(rd0), 32'h0018);
    chk("sat rd1", 32'(rd1), 32'h000f);
    drive(1, 0, 5'd16, 16'h0, '0); cycle();
    chk("sat reread rd0", 32'(rd0), 32'h0000);
    chk("sat reread rd1", 32'(rd1), 32'h000f);

    // Five events on channel 2, read twice
    drive(1, 1, 5'd18, 16'h0, '0); cycle();
    idle(5, 5'h04);
    idle(2, 5'h00);
    drive(1, 0, 5'd18, 16'h0, '0); cycle();
    chk("ch2 rd0", 32'(rd0), 32'h0005);
    chk("ch2 rd1", 32'(rd1), 32'h0005);
    drive(1, 0, 5'd18, 16'h0, '0); cycle();
    chk("ch2 reread rd0", 32'(rd0), 32'h0000);
    chk("ch2 reread rd1", 32'(rd1), 32'h0005);

    // Unknown address
    drive(1, 0, 5'd31, 16'h0, '0); cycle();
    chk("unk err0", 32'(err0), 1);
    chk("unk ack0", 32'(ack0), 0);
    chk("unk ack1", 32'(ack1), 1);
    chk("unk rd1", 32'(rd1), 32'hffff);
    idle(1, 5'h00);

    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 9);
      int k = $urandom_range(0, 4);
      logic [4:0]  a;
      logic [15:0] wd;
      if (r < 6)       a = 5'(16 + $urandom_range(0, NCH - 1));
      else if (r == 6) a = 5'd26;
      else if (r == 7) a = 5'd27;
      else             a = 5'($urandom_range(0, 31));
      case (k)
        0:       wd = 16'h3ffe;
        1:       wd = 16'h0006;
        2:       wd = 16'h7ffd;
        default: wd = 16'($urandom);
      endcase
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, a, wd,
            NCH'($urandom) & NCH'($urandom));
      cycle();
    end

    // Reset while a response is on the bus
    drive(1, 0, 5'd26, 16'h0, '0); cycle();
    chk("pre-reset ack0", 32'(ack0), 1);
    rst = 1'b1;
    #1;
    chk("midreset ack0", 32'(ack0), 0);
    chk("midreset ack1", 32'(ack1), 0);
    chk("midreset err0", 32'(err0), 0);
    chk("midreset irq1", 32'(irq1), 0);
    drive(0, 0, 5'd0, 16'h0, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 0, 5'd26, 16'h0, '0); cycle();
    chk("post-reset isr0", 32'(rd0), 0);
    chk("post-reset isr1", 32'(rd1), 0);
    idle(2, 5'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_event_counters.md
Name: mdio_event_counters

Overview:
- Parametrised successor to the fixed five-counter MDIO register block.
- Provides a bank of CHANNELS saturating event counters on the Wishbone register bus, each COUNTER_WIDTH bits wide.
- Adds an interrupt status register (ISR), an interrupt mask register (IMR) and a registered irq output.
- Sits beside the c22 register block on the same internal Wishbone bus, behind the MDIO slave; PCS/PMA event strobes feed the events inputs.

Parameters:
- CHANNELS, 5, number of event counters; legal range 1..8.
- COUNTER_WIDTH, 15, counter width in bits; legal range 1..16.
- BASE_ADDR, 16, register address of counter 0; counter i is at BASE_ADDR+i.
- ISR_ADDR, 26, address of the interrupt status register.
- IMR_ADDR, 27, address of the interrupt mask register.
- CLEAR_ON_READ, 1, 1 = a counter read reloads the counter; 0 = reads are non-destructive.
- EMULATE_PULLUP, 0, 1 = ack unknown addresses and read them as 16'hffff; 0 = assert err on unknown addresses.

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous and active-high
- cyc  in  1  Wishbone cycle
- stb  in  1  Wishbone strobe
- we  in  1  Wishbone write enable
- addr  in  5  register address
- data_write  in  16  write data
- ack  out  1  transfer acknowledge
- err  out  1  transfer error
- data_read  out  16  read data
- events  in  CHANNELS  per-channel event strobes, one count per high cycle
- irq  out  1  interrupt request, level, active-high

Behaviour:
- Reset (asynchronous, active-high): ack=0, err=0, data_read=0, irq=0; all counters, event registers, ISR and IMR are 0.
- Bus handshake: req = cyc && stb. ack (or err) and data_read are registered and appear exactly 1 cycle after req. A held req produces back-to-back responses, one per cycle. ack and err are never high together.
- Event path: events[i] is registered into ev_q[i] and then added to the counter, so an event reaches the counter 2 cycles after its strobe. The input-to-counter latency is always 2 cycles.
- Saturation: a counter at all-ones ignores ev_q and holds its value. It never wraps.
- Counter read at BASE_ADDR+i: data_read = counter zero-extended to 16 bits.
  - If CLEAR_ON_READ=1, the counter's next value is ev_q[i], so an event arriving on the read cycle is counted afterwards and not lost.
- Counter write: counter = data_write[COUNTER_WIDTH-1:0]; upper bits are ignored. A write overrides an ev_q[i] event on the same cycle, and that event is lost.
- ISR: bit i sets on the cycle counter i's MSB goes 0->1, whether from counting or from a write. Bits CHANNELS..15 read 0.
  - An ISR read returns the current value and then clears it. A set condition on the same cycle wins over the clear.
  - ISR writes are acked and have no effect.
- IMR: read/write on bits [CHANNELS-1:0]; other bits read 0.
- irq: registered each cycle as |(ISR & IMR), one cycle behind ISR. Because of the set-wins rule, irq drops 2 cycles after the ISR read request unless a new set occurs.
- Unknown address:
  - EMULATE_PULLUP=0: err=1, ack=0, no state change, data_read is don't-care.
  - EMULATE_PULLUP=1: ack=1, data_read=16'hffff, writes ignored.
- Elaboration checks (fatal): the range BASE_ADDR..BASE_ADDR+CHANNELS-1 must lie within 0..31 and must not contain ISR_ADDR or IMR_ADDR; ISR_ADDR != IMR_ADDR.
- Reset mid-transfer: any pending ack/err is dropped. The master must re-issue the transfer.

Decomposition:
- Shared header (existing common include): default register addresses (BASE 16, ISR 26, IMR 27) and the pull-up read value, shared with the c22 register block so the address maps stay consistent.
- Sub-module mdio_sat_counter, instantiated once per channel:
  - ports clk, rst, event, load, load_value, clear_to_event;
  - outputs count and msb_rise;
  - contains ev_q, the saturating increment and the MSB edge detect.

Test Plan:
- Reset, then read BASE_ADDR, ISR_ADDR and IMR_ADDR -> each acks 1 cycle later with 16'h0000; irq=0.
- Pulse events[2] for 5 cycles, wait 2 cycles, read BASE_ADDR+2 -> 16'h0005. A second read gives 16'h0000 with CLEAR_ON_READ=1, or 16'h0005 with CLEAR_ON_READ=0.
- COUNTER_WIDTH=4: write 16'h000e to counter 0, then hold events[0] high for 10 cycles -> reads 16'h000f (saturated, no wrap).
- Write IMR=16'h0001, write counter 0 = 16'h3fff (width 15), pulse one event -> ISR bit0=1 and irq=1. Read ISR -> 16'h0001 returned, irq falls 2 cycles after the read request.
- Read counter 1 on the same cycle its registered event is high -> read returns the old value; the following read returns 16'h0001.
- EMULATE_PULLUP=0, read addr 31 -> err=1 and ack=0. EMULATE_PULLUP=1, same read -> ack=1 with 16'hffff.
